mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/mem_arbiter_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 core memory path.
// Imported by the arbiter and its priority picker.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam logic [1:0] STREAK_CAP  = 2'd2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Fetch/data priority pick with a streak-based fairness override.
// Data normally wins; a fetch starved for two data grants wins next.
module arb_pick
  import cpu_pkg::*;
(
  input  logic       en,
  input  logic       if_req,
  input  logic       d_req,
  input  logic [1:0] streak,
  output logic       pick_f,
  output logic       pick_d
);

  logic fw;
  logic dw;

  assign fw = en & if_req & (~d_req | (streak == STREAK_CAP));
  assign dw = en & d_req & ~fw;

  always_comb begin
    pick_f = 1'b0;
    pick_d = 1'b0;
    unique case (1'b1)
      fw:      pick_f = 1'b1;
      dw:      pick_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Stores finish in their grant cycle; reads wait LAT cycles for data.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int BITS = 32,
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [BITS-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [BITS-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [2:0]      d_funct3,
  input  logic [BITS-1:0] d_addr,
  input  logic [BITS-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [BITS-1:0] d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [2:0]      m_funct3,
  output logic [BITS-1:0] m_addr,
  output logic [BITS-1:0] m_wdata,
  input  logic [BITS-1:0] m_rdata,
  output logic            stall
);

  localparam logic [2:0] LAT_W = 3'(LAT);

  state_e     state_q;
  state_e     state_d;
  owner_e     owner_q;
  logic [2:0] cnt_q;
  logic [1:0] streak_q;
  logic       idle;
  logic       pick_f;
  logic       pick_d;
  logic       rd_go;
  logic       last;

  // Gating with rst_n keeps every grant low while reset is held.
  assign idle  = (state_q == IDLE) & rst_n;
  assign rd_go = pick_f | (pick_d & ~d_we);
  assign last  = (state_q == WAIT) & (cnt_q == 3'd1);

  arb_pick u_pick (
    .en     (idle),
    .if_req (if_req),
    .d_req  (d_req),
    .streak (streak_q),
    .pick_f (pick_f),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_go) state_d = WAIT;
      WAIT:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= FETCH;
      cnt_q    <= 3'd0;
      streak_q <= 2'd0;
    end else begin
      if (rd_go) begin
        owner_q <= pick_f ? FETCH : DATA;
        cnt_q   <= LAT_W;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (!if_req || pick_f) begin
        streak_q <= 2'd0;
      end else if (pick_d && streak_q != 2'd3) begin
        streak_q <= streak_q + 2'd1;
      end
    end
  end

  always_comb begin
    if_gnt   = pick_f;
    d_gnt    = pick_d;
    m_en     = pick_f | pick_d;
    m_we     = pick_d & d_we;
    m_funct3 = 3'd0;
    m_addr   = '0;
    m_wdata  = '0;
    unique case (1'b1)
      pick_f: begin
        m_funct3 = FUNCT3_WORD;
        m_addr   = if_addr;
      end
      pick_d: begin
        m_funct3 = d_funct3;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
      end
      default: ;
    endcase
    if_rvalid = last & (owner_q == FETCH);
    d_rvalid  = last & (owner_q == DATA);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;
    stall     = rst_n & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
  end

endmodule
